// File: rtl/hamming_secded_pipe_if.sv
// Stream bundle for the SECDED pipe: producer side (data, injection mask) and
// consumer side (decoded word, clean codeword, syndrome, error flags).
interface hamming_secded_pipe_if #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3
);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_i;
    logic [CODE_W-1:0] inj_mask;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_o;
    logic [CODE_W-1:0] encoded_o;
    logic [PAR_W-1:0]  syndrome_o;
    logic              err_corr;
    logic              err_uncorr;

    modport slave (
        input  in_valid, data_i, inj_mask, out_ready,
        output in_ready, out_valid, data_o, encoded_o, syndrome_o, err_corr, err_uncorr
    );

    modport master (
        output in_valid, data_i, inj_mask, out_ready,
        input  in_ready, out_valid, data_o, encoded_o, syndrome_o, err_corr, err_uncorr
    );
endinterface

// File: rtl/hamming_secded_pipe.sv
// Pipelined SECDED encode -> error injection -> decode with saturating error counters.
// Latency 2 cycles, 1 word/cycle; each stage advances when its successor is empty or draining.
module hamming_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_secded_pipe_if.slave  bus,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt
);
    localparam int CODE_W = DATA_W + PAR_W + 1;
    localparam int KW     = $clog2(DATA_W);

    if (DATA_W < 4 || DATA_W > 64 || (2 ** PAR_W) < CODE_W || (2 ** (PAR_W - 1)) >= DATA_W + PAR_W) begin : g_param_check
        $error("hamming_secded_pipe: PAR_W must be the smallest r with 2^r >= DATA_W+r+1, DATA_W in 4..64");
    end

    // Positions are PAR_W bits wide because 2^PAR_W >= CODE_W > 2^(PAR_W-1).
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [PAR_W-1:0]  acc;
        int                k;
        c   = '0;
        acc = '0;
        k   = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p[PAR_W-1:0]] = d[k[KW-1:0]];
                if (d[k[KW-1:0]]) acc = acc ^ p[PAR_W-1:0];
                k++;
            end
        end
        for (int j = 0; j < PAR_W; j++) begin
            int q;
            q = 1 << j;
            c[q[PAR_W-1:0]] = |(acc & q[PAR_W-1:0]);
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k[KW-1:0]] = c[p[PAR_W-1:0]];
                k++;
            end
        end
        return d;
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [CODE_W-1:0] s1_rx;
    logic              s2_valid;
    logic              s2_load;
    logic              out_hs;

    logic [CODE_W-1:0] enc_word;
    logic [PAR_W-1:0]  syn;
    logic              par;
    logic [CODE_W-1:0] fixed;
    logic              corr;
    logic              uncorr;

    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign bus.out_valid = s2_valid;
    assign out_hs       = s2_valid && bus.out_ready;
    assign enc_word     = encode(bus.data_i);

    always_comb begin
        syn    = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (s1_rx[p[PAR_W-1:0]]) syn = syn ^ p[PAR_W-1:0];
        end
        par    = ^s1_rx;
        fixed  = s1_rx;
        corr   = 1'b0;
        uncorr = 1'b0;
        if (par) begin
            // Odd parity with an out-of-range syndrome means three or more flips.
            if (int'(syn) < CODE_W) begin
                fixed[syn] = ~fixed[syn];
                corr       = 1'b1;
            end else begin
                uncorr = 1'b1;
            end
        end else if (syn != '0) begin
            uncorr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_code        <= '0;
            s1_rx          <= '0;
            s2_valid       <= 1'b0;
            bus.data_o     <= '0;
            bus.encoded_o  <= '0;
            bus.syndrome_o <= '0;
            bus.err_corr   <= 1'b0;
            bus.err_uncorr <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_code <= enc_word;
                    s1_rx   <= enc_word ^ bus.inj_mask;
                end
            end
            if (s2_load) begin
                s2_valid       <= 1'b1;
                bus.data_o     <= extract(fixed);
                bus.encoded_o  <= s1_code;
                bus.syndrome_o <= syn;
                bus.err_corr   <= corr;
                bus.err_uncorr <= uncorr;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (bus.err_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
            if (bus.err_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe: DATA_W=4 (CNT_W=4), 11 and 32 instances against a
// mask-weight model of SECDED behaviour, plus literal vectors.
module tb_hamming_secded_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_cnt = 1'b0;
    logic clr_off = 1'b0;
    always #5 clk = ~clk;

    hamming_secded_pipe_if #(.DATA_W(4),  .PAR_W(3)) ia ();
    hamming_secded_pipe_if #(.DATA_W(11), .PAR_W(4)) ib ();
    hamming_secded_pipe_if #(.DATA_W(32), .PAR_W(6)) ic ();

    logic [3:0]  corr_a, unc_a;
    logic [15:0] corr_b, unc_b, corr_c, unc_c;

    hamming_secded_pipe #(.DATA_W(4), .PAR_W(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ia), .clr_cnt(clr_cnt), .corr_cnt(corr_a), .uncorr_cnt(unc_a));
    hamming_secded_pipe #(.DATA_W(11), .PAR_W(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ib), .clr_cnt(clr_off), .corr_cnt(corr_b), .uncorr_cnt(unc_b));
    hamming_secded_pipe #(.DATA_W(32), .PAR_W(6), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .bus(ic), .clr_cnt(clr_off), .corr_cnt(corr_c), .uncorr_cnt(unc_c));

    typedef struct {
        logic [63:0] d;
        logic [63:0] enc;
        logic [63:0] syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   mc_corr = 0;
    int   mc_unc  = 0;
    logic        a_held = 1'b0;
    logic [63:0] a_hold = '0;
    logic [63:0] a_vec;
    assign a_vec = 64'({ia.err_uncorr, ia.err_corr, ia.syndrome_o, ia.encoded_o, ia.data_o});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Clean codeword: data bits fill non-power-of-two positions; the Hamming parity
    // bits are the binary digits of the XOR of all set data positions.
    function automatic logic [63:0] m_encode(input logic [63:0] d, input int cw);
        logic [63:0] code;
        int k, acc;
        code = '0; k = 0; acc = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k[5:0]]) begin
                    code[p[5:0]] = 1'b1;
                    acc = acc ^ p;
                end
                k++;
            end
        end
        for (int p = 1; p < cw; p = p * 2) code[p[5:0]] = ((acc & p) != 0);
        code[0] = ^code;
        return code;
    endfunction

    function automatic logic [63:0] m_extract(input logic [63:0] c, input int cw);
        logic [63:0] r;
        int k;
        r = '0; k = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[k[5:0]] = c[p[5:0]];
                k++;
            end
        end
        return r;
    endfunction

    // Expected result from the injected mask alone (weight 0, 1 or 2 only).
    function automatic exp_t m_expect(input logic [63:0] d, input logic [63:0] m, input int cw);
        exp_t e;
        int w, s;
        e.enc = m_encode(d, cw);
        w = $countones(m);
        s = 0;
        for (int p = 0; p < cw; p++) if (m[p[5:0]]) s = s ^ p;
        e.syn    = 64'(s);
        e.corr   = (w == 1);
        e.uncorr = (w == 2);
        e.d      = (w == 2) ? m_extract(e.enc ^ m, cw) : d;
        return e;
    endfunction

    task automatic cmp_out(input string tag, input logic [63:0] d, input logic [63:0] enc,
                           input logic [63:0] syn, input logic c, input logic u, input exp_t e);
        chk({tag, "_data"}, d, e.d);
        chk({tag, "_encoded"}, enc, e.enc);
        chk({tag, "_syndrome"}, syn, e.syn);
        chk({tag, "_err_corr"}, 64'(c), 64'(e.corr));
        chk({tag, "_err_uncorr"}, 64'(u), 64'(e.uncorr));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            mc_corr = 0; mc_unc = 0; a_held = 1'b0;
        end else begin
            chk("a_in_ready", 64'(ia.in_ready), 64'(!(qa.size() == 2 && !ia.out_ready)));
            chk("a_corr_cnt", 64'(corr_a), 64'(mc_corr));
            chk("a_uncorr_cnt", 64'(unc_a), 64'(mc_unc));
            if (ia.out_valid) begin
                if (a_held) chk("a_stall_hold", a_vec, a_hold);
                if (qa.size() == 0) begin
                    chk("a_spurious_valid", 64'(qa.size()), 64'd1);
                end else begin
                    e = qa[0];
                    cmp_out("a", 64'(ia.data_o), 64'(ia.encoded_o), 64'(ia.syndrome_o),
                            ia.err_corr, ia.err_uncorr, e);
                    if (ia.out_ready) begin
                        void'(qa.pop_front());
                        if (e.corr && mc_corr < 15) mc_corr++;
                        if (e.uncorr && mc_unc < 15) mc_unc++;
                    end
                end
                a_held = !ia.out_ready;
                a_hold = a_vec;
            end else begin
                if (a_held) chk("a_valid_dropped", 64'(ia.out_valid), 64'd1);
                a_held = 1'b0;
            end
            if (clr_cnt) begin
                mc_corr = 0; mc_unc = 0;
            end
            if (ia.in_valid && ia.in_ready) qa.push_back(m_expect(64'(ia.data_i), 64'(ia.inj_mask), 8));

            chk("b_in_ready", 64'(ib.in_ready), 64'(!(qb.size() == 2 && !ib.out_ready)));
            if (ib.out_valid) begin
                if (qb.size() == 0) chk("b_spurious_valid", 64'(qb.size()), 64'd1);
                else begin
                    cmp_out("b", 64'(ib.data_o), 64'(ib.encoded_o), 64'(ib.syndrome_o),
                            ib.err_corr, ib.err_uncorr, qb[0]);
                    if (ib.out_ready) void'(qb.pop_front());
                end
            end
            if (ib.in_valid && ib.in_ready) qb.push_back(m_expect(64'(ib.data_i), 64'(ib.inj_mask), 16));

            chk("c_in_ready", 64'(ic.in_ready), 64'(!(qc.size() == 2 && !ic.out_ready)));
            if (ic.out_valid) begin
                if (qc.size() == 0) chk("c_spurious_valid", 64'(qc.size()), 64'd1);
                else begin
                    cmp_out("c", 64'(ic.data_o), 64'(ic.encoded_o), 64'(ic.syndrome_o),
                            ic.err_corr, ic.err_uncorr, qc[0]);
                    if (ic.out_ready) void'(qc.pop_front());
                end
            end
            if (ic.in_valid && ic.in_ready) qc.push_back(m_expect(64'(ic.data_i), 64'(ic.inj_mask), 39));
        end
    end

    task automatic put_a(input logic [3:0] d, input logic [7:0] m);
        @(posedge clk); #1;
        ia.in_valid = 1'b1; ia.data_i = d; ia.inj_mask = m;
    endtask
    task automatic put_b(input logic [10:0] d, input logic [15:0] m);
        @(posedge clk); #1;
        ib.in_valid = 1'b1; ib.data_i = d; ib.inj_mask = m;
    endtask
    task automatic put_c(input logic [31:0] d, input logic [38:0] m);
        @(posedge clk); #1;
        ic.in_valid = 1'b1; ic.data_i = d; ic.inj_mask = m;
    endtask
    task automatic idle_all();
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    endtask

    // One word with out_ready high: checks handshake-to-valid latency and literal outputs.
    task automatic lit(input logic [3:0] d, input logic [7:0] m, input logic [3:0] ed,
                       input logic [7:0] ee, input logic [2:0] es, input logic ec, input logic eu);
        int n;
        put_a(d, m);
        @(negedge clk);
        chk("lit_in_ready", 64'(ia.in_ready), 64'd1);
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ia.out_valid && n < 10);
        chk("lit_latency", 64'(n), 64'd2);
        chk("lit_data", 64'(ia.data_o), 64'(ed));
        chk("lit_encoded", 64'(ia.encoded_o), 64'(ee));
        chk("lit_syndrome", 64'(ia.syndrome_o), 64'(es));
        chk("lit_err_corr", 64'(ia.err_corr), 64'(ec));
        chk("lit_err_uncorr", 64'(ia.err_uncorr), 64'(eu));
    endtask

    initial begin
        int i, g;
        bit stream_done;
        logic [7:0] smask;

        ia.in_valid = 1'b0; ia.data_i = '0; ia.inj_mask = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.data_i = '0; ib.inj_mask = '0; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.data_i = '0; ic.inj_mask = '0; ic.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_outputs", a_vec, 64'd0);
        chk("rst_corr_cnt", 64'(corr_a), 64'd0);
        chk("rst_uncorr_cnt", 64'(unc_a), 64'd0);

        lit(4'b1011, 8'h00, 4'b1011, 8'hAA, 3'd0, 1'b0, 1'b0);
        lit(4'b1011, 8'h20, 4'b1011, 8'hAA, 3'd5, 1'b1, 1'b0);
        lit(4'b1011, 8'h01, 4'b1011, 8'hAA, 3'd0, 1'b1, 1'b0);
        lit(4'b1011, 8'h22, 4'b1001, 8'hAA, 3'd4, 1'b0, 1'b1);
        lit(4'b1011, 8'h80, 4'b1011, 8'hAA, 3'd7, 1'b1, 1'b0);
        lit(4'b0000, 8'h00, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0);
        lit(4'b1111, 8'h00, 4'b1111, 8'hFF, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_corr_cnt", 64'(corr_a), 64'd3);
        chk("lit_uncorr_cnt", 64'(unc_a), 64'd1);

        // Stream 0..15 with random consumer stalls.
        stream_done = 1'b0;
        i = 0; g = 0;
        fork
            begin
                @(posedge clk); #1;
                ia.in_valid = 1'b1; ia.data_i = 4'd0; ia.inj_mask = 8'h01;
                while (i < 16 && g < 500) begin
                    @(negedge clk);
                    if (ia.in_ready) i++;
                    @(posedge clk); #1;
                    g++;
                    if (i < 16) begin
                        smask = (i % 3 == 0) ? (8'h01 << (i % 8)) : 8'h00;
                        ia.data_i = 4'(i); ia.inj_mask = smask;
                    end else begin
                        ia.in_valid = 1'b0;
                    end
                end
                chk("stream_accepted", 64'(i), 64'd16);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    ia.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        g = 0;
        while (qa.size() != 0 && g < 50) begin @(negedge clk); g++; end
        chk("stream_drained", 64'(qa.size()), 64'd0);

        // Saturation of the 4-bit corrected-word counter.
        for (int k = 0; k < 20; k++) put_a(4'(k), 8'h20);
        idle_all();
        repeat (4) @(negedge clk);
        chk("sat_corr_cnt", 64'(corr_a), 64'd15);

        // Clear coinciding with an error-word handshake.
        ia.out_ready = 1'b0;
        put_a(4'b0110, 8'h08);
        idle_all();
        g = 0;
        while (!ia.out_valid && g < 10) begin @(negedge clk); g++; end
        chk("clr_word_waiting", 64'(ia.out_valid), 64'd1);
        @(posedge clk); #1;
        ia.out_ready = 1'b1; clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_corr_cnt", 64'(corr_a), 64'd0);
        chk("clr_uncorr_cnt", 64'(unc_a), 64'd0);

        // Every single- and double-bit mask on all three widths.
        for (int j = 0; j < 8; j++) put_a(4'(j * 5), 8'h01 << j);
        for (int j = 0; j < 8; j++)
            for (int k = j + 1; k < 8; k++) put_a(4'(j + k), (8'h01 << j) | (8'h01 << k));
        for (int j = 0; j < 16; j++) put_b(11'(j * 131), 16'h0001 << j);
        for (int j = 0; j < 16; j++)
            for (int k = j + 1; k < 16; k++) put_b(11'(j * 97 + k * 13), (16'h0001 << j) | (16'h0001 << k));
        for (int j = 0; j < 39; j++) put_c(32'hA5C3_0F96 ^ 32'(j), 39'h1 << j);
        for (int j = 0; j < 39; j++)
            for (int k = j + 1; k < 39; k++) put_c(32'(j * 32'h0101_0101) ^ 32'(k * 32'h0F0F_0F0F), (39'h1 << j) | (39'h1 << k));
        idle_all();
        g = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && g < 50) begin @(negedge clk); g++; end
        chk("exh_drained", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

        // Reset with two words in flight.
        ia.out_ready = 1'b0;
        put_a(4'b0101, 8'h00);
        put_a(4'b1010, 8'h04);
        @(posedge clk); #1;
        ia.in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ia.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rstflight_out_valid", 64'(ia.out_valid), 64'd0);
        end
        chk("rstflight_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rstflight_corr_cnt", 64'(corr_a), 64'd0);
        chk("rstflight_uncorr_cnt", 64'(unc_a), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
